// File: rtl/issue_ctrl.sv
// Issue/hazard controller between decode and execute: load scoreboard,
// issue/stall decision and fixed-length flush sequencing after a redirect.
module issue_ctrl #(
    parameter int REG_NUM      = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_is_load_i,
    input  logic                  id_is_csr_i,
    input  logic                  ex_ready_i,
    input  logic                  wb_valid_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic                  redirect_i,
    output logic                  issue_o,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  flush_id_o,
    output logic [REG_NUM-1:0]    pending_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0]       FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]       FC_ZERO = {FC_W{1'b0}};
    localparam logic [FC_W-1:0]       FC_ONE  = FC_W'(1);
    localparam logic [REG_ADDR_W-1:0] A_ZERO  = {REG_ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]      C_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic [REG_NUM-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic hazard_s, not_flush_s, issue_s, stall_s, flush_s;

    // Hazard check reads only the registered scoreboard: no writeback bypass.
    assign hazard_s = ((id_rs1_i != A_ZERO) & pend_q[id_rs1_i])
                    | ((id_rs2_i != A_ZERO) & pend_q[id_rs2_i])
                    | ((id_rd_i  != A_ZERO) & pend_q[id_rd_i])
                    | (id_is_csr_i & (|pend_q));

    // rst_n gating keeps the controls quiet while reset is held.
    assign not_flush_s = (state_q != ST_FLUSH);
    assign issue_s = rst_n & id_valid_i & ex_ready_i & ~hazard_s & ~redirect_i & not_flush_s;
    assign stall_s = rst_n & id_valid_i & ~issue_s & ~redirect_i & not_flush_s;
    assign flush_s = rst_n & (redirect_i | ~not_flush_s);

    assign issue_o     = issue_s;
    assign stall_if_o  = stall_s;
    assign stall_id_o  = stall_s;
    assign flush_id_o  = flush_s;
    assign pending_o   = pend_q;
    assign stall_cnt_o = stall_cnt_q;

    // Next state and flush counter.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FC_LOAD;
                end else if (stall_s) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STALL: begin
                if (redirect_i) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FC_LOAD;
                end else if (issue_s || !id_valid_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_STALL;
                end
            end
            ST_FLUSH: begin
                if (redirect_i) begin
                    flush_cnt_d = FC_LOAD;
                end else if (flush_cnt_q == FC_ZERO) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - FC_ONE;
                end
            end
            default: begin
                state_d     = ST_RUN;
                flush_cnt_d = FC_ZERO;
            end
        endcase
    end

    // Scoreboard update: clear on writeback first, then set on load issue so set wins.
    always_comb begin
        pend_d = pend_q;
        if (wb_valid_i) begin
            pend_d[wb_rd_i] = 1'b0;
        end else begin
            pend_d = pend_d;
        end
        if (issue_s && id_is_load_i && (id_rd_i != A_ZERO)) begin
            pend_d[id_rd_i] = 1'b1;
        end else begin
            pend_d = pend_d;
        end
        pend_d[0] = 1'b0;
    end

    // Stall-cycle counter, wraps freely.
    always_comb begin
        if (stall_s) begin
            stall_cnt_d = stall_cnt_q + C_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, counters and scoreboard registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= FC_ZERO;
            pend_q      <= {REG_NUM{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule
